// File: rtl/uart_line_receiver_pkg.sv
// Shared types and constants for the Uart line receiver: FSM states,
// line status bit positions and the ASCII codes the receiver reacts to.
package uart_line_receiver_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_COMMENT,
    ST_DISCARD,
    ST_CHECKSUM,
    ST_READY
  } line_state_e;

  localparam int LINE_STATUS_OVERFLOW = 0;
  localparam int LINE_STATUS_RXERR    = 1;
  localparam int LINE_STATUS_CHECKSUM = 2;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SEMI = 8'h3B;
  localparam logic [7:0] ASCII_STAR = 8'h2A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  function automatic logic is_eol(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_ZERO + 8'd9);
  endfunction

endpackage

// File: rtl/uart_line_ram.sv
// Line buffer: simple dual-port RAM, synchronous write, registered read.
module uart_line_ram #(
  parameter int depth    = 96,
  parameter int addrBits = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_we,
  input  logic [addrBits-1:0] i_wr_addr,
  input  logic [7:0]          i_wr_data,
  input  logic [addrBits-1:0] i_rd_addr,
  output logic [7:0]          o_rd_data
);

  logic [7:0] r_mem [depth];

  // NOTE: the array has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) o_rd_data <= '0;
    else       o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/uart_line_receiver.sv
// Assembles Uart bytes into command lines, strips ';' comments, holds one line.
// Define UART_LINE_CHECKSUM_EN to add '*nnn' checksum parsing and status bit2.
module uart_line_receiver
  import uart_line_receiver_pkg::*;
#(
  parameter int lineMax  = 96,
  parameter int addrBits = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxFull,
  input  logic                frameError,
  input  logic                parityError,
  input  logic [7:0]          rxData,
  output logic                lineValid,
  output logic [addrBits-1:0] lineLength,
  output logic [2:0]          lineStatus,
  input  logic [addrBits-1:0] lineReadAddr,
  output logic [7:0]          lineReadData,
  input  logic                lineAck,
  output logic                overrun
);

  localparam logic [addrBits-1:0] LINE_MAX = addrBits'(lineMax);

  logic                r_rx_full_q, r_frame_q, r_parity_q;
  logic                r_strobe, r_err_pend, r_overrun;
  logic [7:0]          r_byte;
  line_state_e         r_state;
  logic [addrBits-1:0] r_wr_ptr;
  logic [2:0]          r_status;

  logic                w_err_edge, w_err_pend_next, w_overrun_next, w_we, w_eol;
  line_state_e         w_cur_state, w_state_next;
  logic [addrBits-1:0] w_cur_ptr, w_ptr_next;
  logic [2:0]          w_status_next;

`ifdef UART_LINE_CHECKSUM_EN
  logic [7:0] r_xor, w_xor_next;
  logic [9:0] r_cs_val, w_cs_val_next;
  logic [1:0] r_cs_cnt, w_cs_cnt_next;
  logic       r_cs_bad, w_cs_bad_next, w_cs_err;

  assign w_cs_err = r_cs_bad || (r_cs_cnt == 2'd0) || (r_cs_val != {2'b00, r_xor});
`endif

  assign w_err_edge = (frameError & ~r_frame_q) | (parityError & ~r_parity_q);

  // Edge detection adds one cycle; the FSM acts on the registered strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_full_q <= 1'b0;
      r_frame_q   <= 1'b0;
      r_parity_q  <= 1'b0;
      r_strobe    <= 1'b0;
      r_byte      <= '0;
    end else begin
      r_rx_full_q <= rxFull;
      r_frame_q   <= frameError;
      r_parity_q  <= parityError;
      r_strobe    <= rxFull & ~r_rx_full_q;
      if (rxFull & ~r_rx_full_q) r_byte <= rxData;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_cur_state     = r_state;
    w_cur_ptr       = r_wr_ptr;
    w_status_next   = r_status;
    w_overrun_next  = r_overrun;
    w_err_pend_next = r_err_pend | w_err_edge;
    w_we            = 1'b0;
    w_eol           = 1'b0;
`ifdef UART_LINE_CHECKSUM_EN
    w_xor_next    = r_xor;
    w_cs_val_next = r_cs_val;
    w_cs_cnt_next = r_cs_cnt;
    w_cs_bad_next = r_cs_bad;
`endif

    // An ack releases the line first, so a same-cycle byte opens the next one.
    if (r_state == ST_READY && lineAck) begin
      w_cur_state    = ST_COLLECT;
      w_cur_ptr      = '0;
      w_status_next  = '0;
      w_overrun_next = 1'b0;
    end

    if (w_cur_state != ST_READY && r_err_pend) begin
      w_status_next[LINE_STATUS_RXERR] = 1'b1;
      w_err_pend_next                  = w_err_edge;
    end

    w_state_next = w_cur_state;
    w_ptr_next   = w_cur_ptr;

    if (r_strobe) begin
      case (w_cur_state)
        ST_COLLECT: begin
          if (is_eol(r_byte)) begin
            w_eol = 1'b1;
          end else if (r_byte == ASCII_SEMI) begin
            w_state_next = ST_COMMENT;
`ifdef UART_LINE_CHECKSUM_EN
          end else if (r_byte == ASCII_STAR) begin
            w_state_next = ST_CHECKSUM;
`endif
          end else if (w_cur_ptr == LINE_MAX) begin
            w_status_next[LINE_STATUS_OVERFLOW] = 1'b1;
            w_state_next                        = ST_DISCARD;
          end else begin
            w_we       = 1'b1;
            w_ptr_next = w_cur_ptr + 1'b1;
`ifdef UART_LINE_CHECKSUM_EN
            w_xor_next = r_xor ^ r_byte;
`endif
          end
        end
        ST_COMMENT, ST_DISCARD: begin
          if (is_eol(r_byte)) w_eol = 1'b1;
        end
        ST_CHECKSUM: begin
`ifdef UART_LINE_CHECKSUM_EN
          if (is_eol(r_byte)) begin
            w_status_next[LINE_STATUS_CHECKSUM] = w_cs_err;
            w_eol                               = 1'b1;
          end else if (r_byte == ASCII_SEMI) begin
            w_status_next[LINE_STATUS_CHECKSUM] = w_cs_err;
            w_state_next                        = ST_COMMENT;
          end else if (is_digit(r_byte) && r_cs_cnt != 2'd3) begin
            w_cs_val_next = (r_cs_val << 3) + (r_cs_val << 1) + {6'b0, r_byte[3:0]};
            w_cs_cnt_next = r_cs_cnt + 2'd1;
          end else begin
            w_cs_bad_next = 1'b1;
          end
`else
          if (is_eol(r_byte)) w_eol = 1'b1;
`endif
        end
        ST_READY: w_overrun_next = 1'b1;
        default: ;
      endcase
    end

    // Empty lines without flags (blank lines, second half of CRLF) are dropped.
    if (w_eol) begin
      w_state_next = (w_ptr_next == '0 && w_status_next == '0) ? ST_COLLECT : ST_READY;
`ifdef UART_LINE_CHECKSUM_EN
      w_xor_next    = '0;
      w_cs_val_next = '0;
      w_cs_cnt_next = '0;
      w_cs_bad_next = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_COLLECT;
      r_wr_ptr   <= '0;
      r_status   <= '0;
      r_overrun  <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_ptr   <= w_ptr_next;
      r_status   <= w_status_next;
      r_overrun  <= w_overrun_next;
      r_err_pend <= w_err_pend_next;
    end
  end

`ifdef UART_LINE_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xor    <= '0;
      r_cs_val <= '0;
      r_cs_cnt <= '0;
      r_cs_bad <= 1'b0;
    end else begin
      r_xor    <= w_xor_next;
      r_cs_val <= w_cs_val_next;
      r_cs_cnt <= w_cs_cnt_next;
      r_cs_bad <= w_cs_bad_next;
    end
  end
`endif

  uart_line_ram #(
    .depth    (lineMax),
    .addrBits (addrBits)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_wr_addr (w_cur_ptr),
    .i_wr_data (r_byte),
    .i_rd_addr (lineReadAddr),
    .o_rd_data (lineReadData)
  );

  assign lineValid  = (r_state == ST_READY);
  assign lineLength = r_wr_ptr;
  assign lineStatus = r_status;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_line_receiver.sv
// Directed bench for uart_line_receiver: framing, comments, overflow, overrun,
// rx errors and (when UART_LINE_CHECKSUM_EN is defined) checksum parsing.
module tb_uart_line_receiver;

  logic       clk = 1'b0;
  logic       reset, rxFull, frameError, parityError, lineAck;
  logic [7:0] rxData;
  logic [6:0] lineReadAddr;
  logic       lineValid, overrun;
  logic [6:0] lineLength;
  logic [2:0] lineStatus;
  logic [7:0] lineReadData;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_line_receiver #(.lineMax(96), .addrBits(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .rxFull       (rxFull),
    .frameError   (frameError),
    .parityError  (parityError),
    .rxData       (rxData),
    .lineValid    (lineValid),
    .lineLength   (lineLength),
    .lineStatus   (lineStatus),
    .lineReadAddr (lineReadAddr),
    .lineReadData (lineReadData),
    .lineAck      (lineAck),
    .overrun      (overrun)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] c);
    @(negedge clk);
    rxData = c;
    rxFull = 1'b1;
    repeat (2) @(negedge clk);
    rxFull = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_ack();
    @(negedge clk);
    lineAck = 1'b1;
    @(negedge clk);
    lineAck = 1'b0;
  endtask

  task automatic expect_line(input string name, input logic [6:0] len, input logic [2:0] st);
    n_checks++;
    if (lineValid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s valid: got %b want 1", name, lineValid);
    end
    n_checks++;
    if (lineLength !== len) begin
      n_errors++;
      $display("FAIL %s length: got %0d want %0d", name, lineLength, len);
    end
    n_checks++;
    if (lineStatus !== st) begin
      n_errors++;
      $display("FAIL %s status: got %b want %b", name, lineStatus, st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (lineValid !== 1'b0) begin n_errors++; $display("FAIL reset lineValid: got %b want 0", lineValid); end
    n_checks++;
    if (lineLength !== 7'd0) begin n_errors++; $display("FAIL reset lineLength: got %0d want 0", lineLength); end
    n_checks++;
    if (lineStatus !== 3'b000) begin n_errors++; $display("FAIL reset lineStatus: got %b want 000", lineStatus); end
    n_checks++;
    if (lineReadData !== 8'h00) begin n_errors++; $display("FAIL reset lineReadData: got %h want 00", lineReadData); end
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset overrun: got %b want 0", overrun); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_line();
    string exp_s = "G1 X10";
    send_str(exp_s);
    // Terminator driven by hand to check the two-cycle lineValid latency.
    @(negedge clk);
    rxData = 8'h0A;
    rxFull = 1'b1;
    @(negedge clk);
    n_checks++;
    if (lineValid !== 1'b0) begin n_errors++; $display("FAIL basic early valid: got %b want 0", lineValid); end
    @(negedge clk);
    n_checks++;
    if (lineValid !== 1'b1) begin n_errors++; $display("FAIL basic valid latency: got %b want 1", lineValid); end
    rxFull = 1'b0;
    repeat (2) @(negedge clk);
    expect_line("basic", 7'd6, 3'b000);
    for (int i = 0; i < 6; i++) begin
      lineReadAddr = 7'(i);
      @(negedge clk);
      n_checks++;
      if (lineReadData !== exp_s[i]) begin
        n_errors++;
        $display("FAIL basic read[%0d]: got %h want %h", i, lineReadData, exp_s[i]);
      end
    end
    do_ack();
    n_checks++;
    if (lineValid !== 1'b0) begin n_errors++; $display("FAIL basic after ack: got %b want 0", lineValid); end
  endtask

  task automatic test_blank_and_comment();
    send_str("\r\n");
    n_checks++;
    if (lineValid !== 1'b0) begin n_errors++; $display("FAIL blank presented: got %b want 0", lineValid); end
    send_str("M105 ;temp\r\n");
    expect_line("comment", 7'd5, 3'b000);
    lineReadAddr = 7'd4;
    @(negedge clk);
    n_checks++;
    if (lineReadData !== 8'h20) begin n_errors++; $display("FAIL comment read[4]: got %h want 20", lineReadData); end
    do_ack();
    repeat (6) @(negedge clk);
    n_checks++;
    if (lineValid !== 1'b0) begin n_errors++; $display("FAIL comment extra line: got %b want 0", lineValid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 100; i++) send_byte(8'(65 + i % 26));
    send_byte(8'h0A);
    expect_line("overflow", 7'd96, 3'b001);
    lineReadAddr = 7'd95;
    @(negedge clk);
    n_checks++;
    if (lineReadData !== 8'h52) begin n_errors++; $display("FAIL overflow read[95]: got %h want 52", lineReadData); end
    do_ack();
  endtask

  task automatic test_overrun_and_ack_collision();
    send_str("G1\n");
    expect_line("overrun hold", 7'd2, 3'b000);
    send_byte("X");
    n_checks++;
    if (overrun !== 1'b1) begin n_errors++; $display("FAIL overrun set: got %b want 1", overrun); end
    n_checks++;
    if (lineLength !== 7'd2) begin n_errors++; $display("FAIL overrun length kept: got %0d want 2", lineLength); end
    // Ack lands on the same clock the registered strobe for 'Y' is processed.
    @(negedge clk);
    rxData = "Y";
    rxFull = 1'b1;
    @(negedge clk);
    lineAck = 1'b1;
    @(negedge clk);
    lineAck = 1'b0;
    rxFull  = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL collision overrun: got %b want 0", overrun); end
    n_checks++;
    if (lineValid !== 1'b0) begin n_errors++; $display("FAIL collision valid: got %b want 0", lineValid); end
    repeat (2) @(negedge clk);
    send_byte(8'h0A);
    expect_line("collision", 7'd1, 3'b000);
    lineReadAddr = 7'd0;
    @(negedge clk);
    n_checks++;
    if (lineReadData !== "Y") begin n_errors++; $display("FAIL collision read[0]: got %h want 59", lineReadData); end
    do_ack();
    // An ack while collecting must not disturb the partial line.
    send_str("AB");
    do_ack();
    send_byte(8'h0D);
    expect_line("stray ack", 7'd2, 3'b000);
    do_ack();
  endtask

  task automatic test_rx_error();
    send_str("G2");
    @(negedge clk);
    parityError = 1'b1;
    @(negedge clk);
    parityError = 1'b0;
    send_str("8\n");
    expect_line("rx error", 7'd3, 3'b010);
    lineReadAddr = 7'd2;
    @(negedge clk);
    n_checks++;
    if (lineReadData !== "8") begin n_errors++; $display("FAIL rx error read[2]: got %h want 38", lineReadData); end
    do_ack();
  endtask

`ifdef UART_LINE_CHECKSUM_EN
  task automatic test_checksum();
    send_str("N1 G28*18\n");
    expect_line("checksum good", 7'd6, 3'b000);
    do_ack();
    send_str("N1 G28*19\n");
    expect_line("checksum bad", 7'd6, 3'b100);
    do_ack();
    send_str("N1 G28*\n");
    expect_line("checksum empty", 7'd6, 3'b100);
    do_ack();
  endtask
`else
  task automatic test_checksum();
    send_str("N1 G28*18\n");
    expect_line("star plain", 7'd9, 3'b000);
    lineReadAddr = 7'd6;
    @(negedge clk);
    n_checks++;
    if (lineReadData !== "*") begin n_errors++; $display("FAIL star plain read[6]: got %h want 2a", lineReadData); end
    do_ack();
  endtask
`endif

  initial begin
    reset        = 1'b1;
    rxFull       = 1'b0;
    frameError   = 1'b0;
    parityError  = 1'b0;
    rxData       = 8'h00;
    lineAck      = 1'b0;
    lineReadAddr = 7'd0;
    test_reset();
    test_basic_line();
    test_blank_and_comment();
    test_overflow();
    test_overrun_and_ack_collision();
    test_rx_error();
    test_checksum();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_line_receiver.md
# uart_line_receiver

- Consumes the parallel receive side of the Uart block and assembles incoming bytes into complete command lines for the G-code parser.
- Detects each received character and strips `;` comments.
- Terminates lines on CR or LF and holds one finished line in an internal buffer.
- The parser reads the held line by address and releases it with an acknowledge.

## Interface
Parameters:
- `lineMax`, 96: maximum stored characters per line (2..127).
- `addrBits`, 7: width of the line address and length; must satisfy `2**addrBits > lineMax`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rxFull`  in  1  from Uart; stays high while `rxData` is valid; a rising edge marks a new byte.
- `frameError`  in  1  from Uart; a rising edge marks a bad character.
- `parityError`  in  1  from Uart; a rising edge marks a bad character.
- `rxData`  in  8  character; Uart `rxData[7:0]`.
- `lineValid`  out  1  a finished line is held.
- `lineLength`  out  addrBits  stored character count; valid while `lineValid`.
- `lineStatus`  out  3  per-line flags, valid while `lineValid`:
  - bit0: overflow/truncated.
  - bit1: rx frame or parity error.
  - bit2: checksum error.
- `lineReadAddr`  in  addrBits  character index to read.
- `lineReadData`  out  8  character at `lineReadAddr`, registered.
- `lineAck`  in  1  consumer releases the line.
- `overrun`  out  1  sticky; a byte arrived while a line was held; cleared on `lineAck`.

## Operation
Reset values:
- `lineValid`, `lineLength`, `lineStatus`, `lineReadData` and `overrun` are 0.
- State is `Collect`.
- The `rxFull`/error edge registers are 0.

Byte detection:
- A byte strobe occurs when `rxFull` is 1 and its registered value from the previous cycle is 0.
- A rising edge on `frameError` or `parityError` sets the pending rx-error flag.

States:
- **Collect**:
  - A byte that is not CR/LF/`;` is written at `wrPtr`, and `wrPtr` increments.
  - If `wrPtr == lineMax`, the byte is discarded, status bit0 is set, and the state goes to `Discard`.
  - `;` goes to `Comment`.
  - CR/LF ends the line:
    - `wrPtr == 0` with no flags set: ignored, stay in `Collect`. This covers blank lines and the CRLF second terminator.
    - Otherwise: go to `Ready`.
- **Comment** and **Discard**: drop bytes until CR/LF, then apply the same end-of-line rule.
- **Ready**:
  - `lineValid` is 1.
  - Byte strobes are dropped and set `overrun`.
  - `lineAck` clears `wrPtr`, status and `overrun`, and returns to `Collect`.
- A pending rx-error sets status bit1 for the line being assembled.
- A line holding only error flags (empty, flags set) is still presented.
- `lineAck` outside `Ready` is ignored.
- **Simultaneous ack and byte strobe in Ready:**
  - The ack takes effect.
  - The byte is processed as the first byte of the new line in `Collect`.
  - `overrun` is not set.
- `lineReadAddr >= lineLength` returns undefined data; no error is raised.
- Reset mid-line discards all partial contents.

## Timing
- Strobe detection takes 1 cycle after `rxFull` rises; the byte is written in the following cycle.
- `lineValid` rises 2 cycles after `rxFull` rises for the terminating CR/LF.
- Read latency is 1: `lineReadAddr` at cycle N gives `lineReadData` at N+1. Reads are permitted in any state.
- `lineValid` falls the cycle after `lineAck` is sampled high.
- The minimum byte spacing accepted is 3 clocks; the Uart guarantees far more.
- `wrPtr` and `lineLength` are `addrBits` unsigned and cannot wrap because `lineMax < 2**addrBits`.

## Configuration
- `UART_LINE_CHECKSUM_EN` defined:
  - A running XOR is taken over every stored byte before `*`.
  - `*` enters state `Checksum`; up to 3 decimal digits accumulate into a 10-bit value.
  - At CR/LF, status bit2 is set if there is a non-digit, more than 3 digits, zero digits, or value != XOR.
  - `*` and the digits are not stored.
  - `;` inside `Checksum` ends digit parsing and then behaves as `Comment`.
- Not defined:
  - `*` is an ordinary stored character.
  - Status bit2 is constant 0.
  - No XOR or digit logic is synthesised.

## Structure
- UartPackage gains:
  - The `LineState` enum: Collect, Comment, Discard, Checksum, Ready.
  - `LINE_STATUS_OVERFLOW`/`RXERR`/`CHECKSUM` bit index constants.
  - ASCII constants for CR, LF, `;`, `*`, `0`.
- Sub-module `uart_line_ram`: a `lineMax` x 8 simple dual-port RAM with one synchronous write port and one registered read port. It infers block or distributed RAM.

## Test plan
- Send "G1 X10\n" → `lineValid`, `lineLength`=6, `lineStatus`=0; reads at addr 0..5 return "G1 X10"; `lineAck` → `lineValid`=0 the next cycle.
- Send "\r\n" then "M105 ;temp\r\n" → one line, length 5 ("M105 "), status 0; no empty line is presented.
- Send 100 non-terminator bytes then LF with `lineMax`=96 → length 96, status bit0 set; bytes 97-100 absent.
- While holding a line, send "X" → `overrun`=1; ack with a byte strobe in the same cycle → new line starts with that byte and `overrun`=0.
- Pulse `parityError` mid "G28\n" → line length 3, status bit1 set.
- With `UART_LINE_CHECKSUM_EN` defined:
  - "N1 G28*18\n" → status bit2=0, length 6.
  - "N1 G28*19\n" → bit2=1.
  - "N1 G28*\n" → bit2=1.
